// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage owning the regfile, wbk forwarding, minstret and retire trace
module writeback_stage #(
  parameter int XLEN = 32,
  parameter int IID_W = 64,
  parameter logic [XLEN-1:0] RESET_PC_TRACE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             is_new,
  input  logic [IID_W-1:0] inst_id,
  input  logic [XLEN-1:0]  pc,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [1:0]       instret_we,
  input  logic [31:0]      instret_wdata,
  output logic [XLEN-1:0]  regfile [32],
  output logic [XLEN+6:0]  fw_wbk,
  output logic [63:0]      instret,
  output logic             retire_valid,
  output logic [IID_W-1:0] retire_inst_id,
  output logic [XLEN-1:0]  retire_pc
);
  logic             s_valid, s_is_new, s_wb_en;
  logic [IID_W-1:0] s_inst_id;
  logic [XLEN-1:0]  s_pc, s_wb_data;
  logic [4:0]       s_wb_addr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_valid   <= 1'b0;
      s_is_new  <= 1'b0;
      s_inst_id <= '0;
      s_pc      <= '0;
      s_wb_en   <= 1'b0;
      s_wb_addr <= '0;
      s_wb_data <= '0;
    end else begin
      s_valid   <= valid;
      s_is_new  <= is_new;
      s_inst_id <= inst_id;
      s_pc      <= pc;
      s_wb_en   <= wb_en;
      s_wb_addr <= wb_addr;
      s_wb_data <= wb_data;
    end
  end
  // wbk data is always final, so fwdable simply follows valid
  assign fw_wbk         = (s_valid && s_wb_en) ? {2'b11, s_wb_addr, s_wb_data} : '0;
  assign retire_valid   = s_valid && s_is_new;
  assign retire_inst_id = retire_valid ? s_inst_id : '0;
  assign retire_pc      = retire_valid ? s_pc : RESET_PC_TRACE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (s_valid && s_wb_en && s_wb_addr != 5'd0) begin
      regfile[s_wb_addr] <= s_wb_data;
    end
  end
  // a CSR write to minstret suppresses the retire increment of the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (|instret_we) begin
      if (instret_we[0]) instret[31:0] <= instret_wdata;
      if (instret_we[1]) instret[63:32] <= instret_wdata;
    end else if (retire_valid) begin
      instret <= instret + 64'd1;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table vectors, hand sequences and randomized run against a behavioural model
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n, valid, is_new, wb_en;
  logic [63:0] inst_id;
  logic [31:0] pc, wb_data, instret_wdata;
  logic [4:0]  wb_addr;
  logic [1:0]  instret_we;
  logic [31:0] rf_o [32];
  logic [38:0] fw_wbk;
  logic [63:0] instret, retire_inst_id;
  logic        retire_valid;
  logic [31:0] retire_pc;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .is_new(is_new), .inst_id(inst_id), .pc(pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .instret_we(instret_we),
    .instret_wdata(instret_wdata), .regfile(rf_o), .fw_wbk(fw_wbk), .instret(instret),
    .retire_valid(retire_valid), .retire_inst_id(retire_inst_id), .retire_pc(retire_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: architectural registers, retired count and the occupant of the stage
  logic [31:0] m_rf [32];
  logic [63:0] m_instret;
  logic        p_valid, p_new, p_en;
  logic [4:0]  p_addr;
  logic [31:0] p_data, p_pc;
  logic [63:0] p_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_instret = '0;
      p_valid = 1'b0; p_new = 1'b0; p_en = 1'b0;
      p_addr = '0; p_data = '0; p_pc = '0; p_id = '0;
    end else begin
      if (p_valid && p_en && p_addr != 0) m_rf[p_addr] = p_data;
      if (instret_we != 0) begin
        if (instret_we[0]) m_instret[31:0] = instret_wdata;
        if (instret_we[1]) m_instret[63:32] = instret_wdata;
      end else if (p_valid && p_new) begin
        m_instret = m_instret + 1;
      end
      p_valid = valid; p_new = is_new; p_en = wb_en;
      p_addr = wb_addr; p_data = wb_data; p_pc = pc; p_id = inst_id;
    end
  endtask

  task automatic model_check();
    logic        ret;
    logic [38:0] fw;
    int          bad;
    ret = p_valid && p_new;
    fw  = (p_valid && p_en) ? {2'b11, p_addr, p_data} : 39'd0;
    chk("model fw_wbk", {25'd0, fw_wbk}, {25'd0, fw});
    chk("model retire_valid", {63'd0, retire_valid}, {63'd0, ret});
    chk("model instret", instret, m_instret);
    if (ret) begin
      chk("model retire_inst_id", retire_inst_id, p_id);
      chk("model retire_pc", {32'd0, retire_pc}, {32'd0, p_pc});
    end else begin
      chk("model retire_pc idle", {32'd0, retire_pc}, 64'd0);
    end
    bad = -1;
    for (int i = 31; i >= 0; i--) if (rf_o[i] !== m_rf[i]) bad = i;
    chk("model regfile first bad index", {32'd0, bad}, {32'd0, 32'hFFFF_FFFF});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input logic v, input logic n, input logic en, input logic [4:0] a,
                       input logic [31:0] d, input logic [1:0] we, input logic [31:0] wd);
    valid = v; is_new = n; wb_en = en; wb_addr = a; wb_data = d;
    instret_we = we; instret_wdata = wd;
    inst_id = {$urandom, $urandom}; pc = $urandom;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0);
  endtask

  typedef struct {
    logic        v, n, en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [38:0] exp_fw;
    logic        exp_ret;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [63:0] base;
    int          pulses;
    vt[0] = '{1'b1, 1'b1, 1'b1, 5'd10, 32'hA5A5_A5A5, {2'b11, 5'd10, 32'hA5A5_A5A5}, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b1, 5'd10, 32'h0BAD_F00D, {2'b11, 5'd10, 32'h0BAD_F00D}, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0077, 39'd0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_0088, 39'd0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 5'd0,  32'h0000_1234, {2'b11, 5'd0, 32'h0000_1234}, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, {2'b11, 5'd31, 32'hFFFF_FFFF}, 1'b1};

    // reset with an instruction presented: nothing may be captured or counted
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h1111_2222, 2'b00, 32'd0);
    tick();
    tick();
    chk("reset instret", instret, 64'd0);
    chk("reset fw_wbk", {25'd0, fw_wbk}, 64'd0);
    chk("reset retire_valid", {63'd0, retire_valid}, 64'd0);
    chk("reset retire_inst_id", retire_inst_id, 64'd0);
    chk("reset regfile[9]", {32'd0, rf_o[9]}, 64'd0);
    rst_n = 1'b1;

    // write x5: forwarded in N+1, architectural in N+2
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 32'd0);
    tick();
    chk("x5 fw_wbk", {25'd0, fw_wbk}, {25'd0, 2'b11, 5'd5, 32'hDEAD_BEEF});
    chk("x5 retire_valid", {63'd0, retire_valid}, 64'd1);
    chk("x5 regfile not yet", {32'd0, rf_o[5]}, 64'd0);
    idle();
    tick();
    chk("x5 regfile", {32'd0, rf_o[5]}, 64'hDEAD_BEEF);
    chk("x5 instret", instret, 64'd1);

    // table vectors: outputs of the cycle each vector occupies the stage
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].n, vt[i].en, vt[i].a, vt[i].d, 2'b00, 32'd0);
      tick();
      chk($sformatf("vec%0d fw_wbk", i), {25'd0, fw_wbk}, {25'd0, vt[i].exp_fw});
      chk($sformatf("vec%0d retire", i), {63'd0, retire_valid}, {63'd0, vt[i].exp_ret});
    end
    idle();
    tick();
    chk("x0 stays zero", {32'd0, rf_o[0]}, 64'd0);
    chk("x31 written", {32'd0, rf_o[31]}, 64'hFFFF_FFFF);
    chk("table instret", instret, 64'd5);

    // stall: one instruction presented three cycles retires exactly once
    base = instret;
    pulses = 0;
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h55, 2'b00, 32'd0);
    tick();
    pulses += int'(retire_valid);
    is_new = 1'b0;
    tick();
    pulses += int'(retire_valid);
    tick();
    pulses += int'(retire_valid);
    idle();
    tick();
    pulses += int'(retire_valid);
    chk("stall retire pulses", 64'(pulses), 64'd1);
    chk("stall instret delta", instret - base, 64'd1);
    chk("stall regfile[7]", {32'd0, rf_o[7]}, 64'h55);

    // CSR write collides with a retire: write wins, then carry into the high half
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b11, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 32'hFFFF_FFFF);
    tick();
    chk("csr preset", instret, 64'h0000_0000_FFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 2'b10, 32'hA);
    tick();
    chk("csr collision", instret, 64'h0000_000A_FFFF_FFFF);
    idle();
    tick();
    chk("csr carry", instret, 64'h0000_000B_0000_0000);

    // full 64-bit wrap
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 32'hFFFF_FFFF);
    tick();
    idle();
    tick();
    chk("instret wrap", instret, 64'd0);

    // reset mid-flight drops the captured instruction
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h99, 2'b00, 32'd0);
    tick();
    rst_n = 1'b0;
    idle();
    tick();
    chk("midreset regfile[3]", {32'd0, rf_o[3]}, 64'd0);
    chk("midreset instret", instret, 64'd0);
    chk("midreset retire", {63'd0, retire_valid}, 64'd0);
    rst_n = 1'b1;

    // randomized traffic with rare CSR writes and resets
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 12)), $urandom,
            ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00, $urandom);
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
